vector_checker: RTL and testbench
=================================

# vector_checker

Synthesizable, parametrised self-checking test-vector engine for the adder and arithmetic blocks. Holds a vector memory loaded through a write port. On `start` it streams stimulus to a DUT one vector per cycle and compares the DUT response, after a fixed pipeline latency, against masked expected values. It counts errors, records the first failing index and reports pass/fail. It sits between the vector source (loader or host) and any DUT on the same clock.

## Interface
Parameters:
- `IN_W`, 8: stimulus width per vector.
- `OUT_W`, 8: DUT response width; also the width of the expected and mask fields.
- `DEPTH`, 16: vector memory entries, ≥2.
- `LAT`, 0: DUT latency in cycles from `stim` to a valid `resp`, 0..8.
- `ERR_W`, 8: width of the error counter.
- Derived: `AW` = $clog2(DEPTH); `NW` = $clog2(DEPTH+1); `VW` = IN_W+2*OUT_W.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `load_en`  in  1  write `load_data` to `load_addr`.
- `load_addr`  in  AW  memory write address.
- `load_data`  in  VW  vector fields {stim[IN_W], exp[OUT_W], mask[OUT_W]}; mask bit 1 means compare that bit.
- `num_vec`  in  NW  number of vectors to run; sampled on `start`; values above DEPTH are clamped to DEPTH.
- `start`  in  1  single-cycle run request.
- `resp`  in  OUT_W  DUT response.
- `stim`  out  IN_W  stimulus to the DUT; registered.
- `stim_valid`  out  1  `stim` carries a vector this cycle.
- `busy`  out  1  run in progress (RUN or DRAIN).
- `done`  out  1  run complete; level signal.
- `pass`  out  1  `done` && `errors`==0.
- `errors`  out  ERR_W  mismatch count; saturates at 2^ERR_W−1.
- `first_err`  out  AW  index of the first mismatching vector; valid when `errors`≠0.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start` with `num_vec`≠0 → RUN. Latch the clamped count, clear `errors`/`first_err`, read address 0.
  - `start` with `num_vec`==0 → DONE with `errors`=0.
- RUN:
  - Present `stim` = mem[k].stim with `stim_valid`=1 for k = 0..N−1, one vector per cycle.
  - Push {exp, mask, k, valid} into a LAT-deep check pipe.
  - After vector N−1 is presented: → DRAIN if LAT>0, else → DONE.
- DRAIN: wait LAT cycles until the pipe empties, then → DONE.
- Check rule: vector k mismatches when ((resp ^ exp) & mask) ≠ 0, evaluated in the cycle the pipe entry for k is at its output.
  - On a mismatch, increment `errors` (saturating).
  - On the first mismatch, capture k into `first_err`.
  - A mask of all zeros always passes.
- DONE: hold `done`, `pass`, `errors` and `first_err`. `start` begins a new run (same rules as IDLE); otherwise remain in DONE.
- `start` is ignored while `busy`.
- `load_en` is ignored while `busy`; writes in IDLE or DONE take effect immediately.
- `stim` holds its last value when `stim_valid`=0.
- Memory contents are not cleared by `reset`.
- Reset mid-run: abort immediately, enter IDLE, flush the pipe and set all outputs to reset values. A subsequent `start` runs from vector 0.

## Timing
- Reset values: `stim`=0, `stim_valid`=0, `busy`=0, `done`=0, `pass`=0, `errors`=0, `first_err`=0, FSM=IDLE.
- `start` sampled at edge 0 → `stim`=vec0 and `stim_valid`=1 in cycle 1. Vector k is presented in cycle 1+k.
- `resp` for vector k is sampled in cycle 1+k+LAT. The resulting `errors` update is visible in cycle 2+k+LAT.
- `done` rises in cycle N+LAT+1 with final `errors`; `busy` falls in the same cycle. Total latency from `start` to `done` = N+LAT+1 cycles.
- `num_vec`==0: `done`=1 in cycle 1, `pass`=1.
- Back-to-back runs: `start` in DONE clears `done`/`pass` and produces vec0 in the next cycle.

## Test plan
- IN_W=8, OUT_W=8, LAT=0; load 4 vectors with exp = stim+1 and mask=FF; DUT = increment; `num_vec`=4 → `stim` 1..4 cycles, `done` in cycle 5, `pass`=1, `errors`=0.
- Same setup with vector 2 exp corrupted (bit 0 flipped) → `errors`=1, `first_err`=2, `pass`=0. Repeat with mask bit 0 cleared on that vector → `pass`=1.
- LAT=3 with a 3-stage registered DUT, `num_vec`=DEPTH=16 → `done` in cycle 20; no false errors. Inject a mismatch on vector 15 → caught during DRAIN, `first_err`=15.
- ERR_W=2, all 16 vectors mismatching → `errors` saturates at 3, `first_err`=0.
- `num_vec`=0 → `done`/`pass` in cycle 1. `num_vec`=31 with DEPTH=16 → clamped to 16 vectors.
- `reset` asserted in cycle 3 of a run → next cycle all outputs at reset values. `start`/`load_en` while `busy` are ignored. A rerun after reset re-presents vec0 and reproduces identical results.

Source files
------------

// File: rtl/vector_checker.sv
// vector_checker: streams stored test vectors into a DUT one per cycle and
// compares the DUT response, LAT cycles later, against masked expected values.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | out of reset, waiting for start
// S_RUN   | presenting vectors 0..N-1, one per cycle
// S_DRAIN | all vectors presented, waiting for the check pipe to empty
// S_DONE  | results held; start begins a new run
module vector_checker #(
  parameter  int IN_W  = 8,
  parameter  int OUT_W = 8,
  parameter  int DEPTH = 16,
  parameter  int LAT   = 0,
  parameter  int ERR_W = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int NW    = $clog2(DEPTH + 1),
  localparam int VW    = IN_W + 2 * OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [VW-1:0]    load_data,
  input  logic [NW-1:0]    num_vec,
  input  logic             start,
  input  logic [OUT_W-1:0] resp,
  output logic [IN_W-1:0]  stim,
  output logic             stim_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] errors,
  output logic [AW-1:0]    first_err
);

  localparam int PW = 2 * OUT_W + AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [VW-1:0]    r_mem [DEPTH];
  logic [IN_W-1:0]  r_stim;
  logic             r_stim_valid;
  logic [OUT_W-1:0] r_exp;
  logic [OUT_W-1:0] r_mask;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    r_last;
  logic [3:0]       r_drain;
  logic [ERR_W-1:0] r_errors;
  logic [AW-1:0]    r_first_err;

  logic [NW-1:0]    w_n;
  logic             w_last;
  logic [AW-1:0]    w_rd_addr;
  logic [VW-1:0]    w_rd;
  logic [PW-1:0]    w_pipe_in;
  logic [PW-1:0]    w_chk;
  logic [OUT_W-1:0] w_chk_exp;
  logic [OUT_W-1:0] w_chk_mask;
  logic [AW-1:0]    w_chk_idx;
  logic             w_chk_valid;
  logic             w_mismatch;

  assign w_n       = (num_vec > NW'(DEPTH)) ? NW'(DEPTH) : num_vec;
  assign w_last    = (r_idx == r_last);
  // Outside RUN the read port points at vector 0 so a start can load it directly.
  assign w_rd_addr = (r_state == S_RUN) ? r_idx + 1'b1 : '0;
  assign w_rd      = r_mem[w_rd_addr];

  // Vector memory: writable only while no run is in progress; never reset.
  always_ff @(posedge clk) begin
    if (load_en && !busy) r_mem[load_addr] <= load_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = (num_vec == '0) ? S_DONE : S_RUN;
      S_RUN:          if (w_last) w_next = (LAT > 0) ? S_DRAIN : S_DONE;
      S_DRAIN:        if (r_drain == 4'd0) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Each presented vector carries its expected value, mask and index down the check pipe.
  assign w_pipe_in = {r_exp, r_mask, r_idx, r_stim_valid};

  generate
    if (LAT == 0) begin : g_nopipe
      assign w_chk = w_pipe_in;
    end else begin : g_pipe
      logic [PW-1:0] r_pipe [LAT];
      // Delay line matching the DUT latency; reset clears the valid bits.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_pipe_in;
          for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_chk = r_pipe[LAT-1];
    end
  endgenerate

  assign w_chk_exp   = w_chk[PW-1 -: OUT_W];
  assign w_chk_mask  = w_chk[PW-1-OUT_W -: OUT_W];
  assign w_chk_idx   = w_chk[AW:1];
  assign w_chk_valid = w_chk[0];
  assign w_mismatch  = w_chk_valid && (|((resp ^ w_chk_exp) & w_chk_mask));

  // Stimulus sequencing, drain timer and error bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stim       <= '0;
      r_stim_valid <= 1'b0;
      r_exp        <= '0;
      r_mask       <= '0;
      r_idx        <= '0;
      r_last       <= '0;
      r_drain      <= '0;
      r_errors     <= '0;
      r_first_err  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_errors    <= '0;
            r_first_err <= '0;
            r_idx       <= '0;
            r_last      <= AW'(w_n - 1'b1);
            if (num_vec != '0) begin
              {r_stim, r_exp, r_mask} <= w_rd;
              r_stim_valid            <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_stim_valid <= 1'b0;
            r_drain      <= 4'(LAT - 1);
          end else begin
            r_idx                   <= r_idx + 1'b1;
            {r_stim, r_exp, r_mask} <= w_rd;
          end
        end
        S_DRAIN: r_drain <= r_drain - 1'b1;
        default: ;
      endcase
      if (w_mismatch) begin
        if (r_errors != '1) r_errors <= r_errors + 1'b1;
        if (r_errors == '0) r_first_err <= w_chk_idx;
      end
    end
  end

  assign stim       = r_stim;
  assign stim_valid = r_stim_valid;
  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign pass       = done && (r_errors == '0);
  assign errors     = r_errors;
  assign first_err  = r_first_err;

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: two instances (LAT=0 with a 2-bit error counter,
// LAT=3 with an 8-bit counter) driven from a shared load bus, each with an
// increment DUT. A bench-side copy of the vector memory predicts the stimulus
// stream and final results; both are queued at start and popped as the DUT
// presents vectors and raises done.
module tb_vector_checker;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [23:0] load_data;
  logic [4:0]  num_vec;
  logic        start_a, start_b;
  logic [7:0]  resp_a, resp_b;
  logic [7:0]  stim_a, stim_b;
  logic        sv_a, sv_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [1:0]  errors_a;
  logic [7:0]  errors_b;
  logic [3:0]  fe_a, fe_b;

  always #5 clk = ~clk;

  vector_checker #(.IN_W(8), .OUT_W(8), .DEPTH(DEPTH), .LAT(0), .ERR_W(2)) u_a (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start_a), .resp(resp_a),
    .stim(stim_a), .stim_valid(sv_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .errors(errors_a), .first_err(fe_a));

  vector_checker #(.IN_W(8), .OUT_W(8), .DEPTH(DEPTH), .LAT(3), .ERR_W(8)) u_b (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start_b), .resp(resp_b),
    .stim(stim_b), .stim_valid(sv_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .errors(errors_b), .first_err(fe_b));

  // DUT models: combinational increment, and a 3-stage registered increment.
  assign resp_a = stim_a + 8'd1;
  logic [7:0] p1, p2, p3;
  always_ff @(posedge clk) begin
    p1 <= stim_b + 8'd1;
    p2 <= p1;
    p3 <= p2;
  end
  assign resp_b = p3;

  // Monitor mux selecting the instance under test.
  int         sel;
  logic [7:0] mon_stim;
  logic       mon_sv, mon_busy, mon_done, mon_pass;
  int         mon_err, mon_fe;
  always_comb begin
    if (sel == 0) begin
      mon_stim = stim_a; mon_sv = sv_a; mon_busy = busy_a; mon_done = done_a;
      mon_pass = pass_a; mon_err = int'(errors_a); mon_fe = int'(fe_a);
    end else begin
      mon_stim = stim_b; mon_sv = sv_b; mon_busy = busy_b; mon_done = done_b;
      mon_pass = pass_b; mon_err = int'(errors_b); mon_fe = int'(fe_b);
    end
  end

  logic [7:0] m_stim [DEPTH];
  logic [7:0] m_exp  [DEPTH];
  logic [7:0] m_mask [DEPTH];

  typedef struct {int cyc; int e; int fe;} res_t;
  res_t       rq[$];
  logic [7:0] sq[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic load(input int a, input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
    @(negedge clk);
    load_en = 1'b1; load_addr = 4'(a); load_data = {s, e, m};
    m_stim[a] = s; m_exp[a] = e; m_mask[a] = m;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic load_all(input bit invert);
    logic [7:0] s;
    for (int k = 0; k < DEPTH; k++) begin
      s = (k == 3) ? 8'hFF : 8'(k * 37 + 11);
      load(k, s, invert ? ~(s + 8'd1) : s + 8'd1, 8'hFF);
    end
  endtask

  // One run on instance s. poke_c: cycle in which start and a load are driven
  // while busy. rst_c: cycle in which reset is asserted (run aborted).
  task automatic run(input int s, input int nv, input int poke_c, input int rst_c);
    int n, lat, maxe, c, seen;
    logic [7:0] r, st;
    res_t res;
    sel = s; lat = s ? 3 : 0; maxe = s ? 255 : 3;
    n = (nv > DEPTH) ? DEPTH : nv;
    res.e = 0; res.fe = 0; res.cyc = (n == 0) ? 1 : n + lat + 1;
    for (int k = 0; k < n; k++) begin
      sq.push_back(m_stim[k]);
      r = m_stim[k] + 8'd1;
      if (((r ^ m_exp[k]) & m_mask[k]) != 8'd0) begin
        if (res.e == 0) res.fe = k;
        if (res.e < maxe) res.e++;
      end
    end
    rq.push_back(res);
    @(negedge clk);
    num_vec = 5'(nv);
    if (s != 0) start_b = 1'b1; else start_a = 1'b1;
    c = 0; seen = 0;
    while (1) begin
      @(negedge clk);
      c++;
      start_a = 1'b0; start_b = 1'b0; load_en = 1'b0;
      if (mon_sv) begin
        seen++;
        if (sq.size() == 0) chk("extra_stim", 1, 0);
        else begin st = sq.pop_front(); chk("stim", int'(mon_stim), int'(st)); end
      end
      if (c == 1 && n > 0) chk("busy", int'(mon_busy), 1);
      if (c == rst_c) begin
        reset = 1'b1;
        @(negedge clk);
        chk("reset_outs", int'({mon_stim, mon_sv, mon_busy, mon_done, mon_pass,
                                8'(mon_err), 4'(mon_fe)}), 0);
        reset = 1'b0;
        sq.delete(); rq.delete();
        return;
      end
      if (c == poke_c) begin
        if (s != 0) start_b = 1'b1; else start_a = 1'b1;
        load_en = 1'b1; load_addr = 4'd5; load_data = {8'hEE, 8'h00, 8'hFF};
      end
      if (mon_done) begin
        res = rq.pop_front();
        chk("done_cycle", c, res.cyc);
        chk("errors", mon_err, res.e);
        chk("first_err", mon_fe, res.fe);
        chk("pass", int'(mon_pass), int'(res.e == 0));
        chk("busy_at_done", int'(mon_busy), 0);
        chk("n_presented", seen, n);
        break;
      end
      if (c > 100) begin
        chk("timeout", c, 0);
        sq.delete(); rq.delete();
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    num_vec = '0; start_a = 1'b0; start_b = 1'b0; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_a", int'({stim_a, sv_a, busy_a, done_a, pass_a, errors_a, fe_a}), 0);
    chk("reset_b", int'({stim_b, sv_b, busy_b, done_b, pass_b, errors_b, fe_b}), 0);
    reset = 1'b0;

    load_all(1'b0);
    run(0, 4, -1, -1);                                   // clean 4-vector run
    load(2, m_stim[2], m_exp[2] ^ 8'h01, 8'hFF);
    run(0, 4, -1, -1);                                   // bit-0 mismatch on vec 2
    load(2, m_stim[2], m_exp[2], 8'hFE);
    run(0, 4, -1, -1);                                   // masked away
    run(1, 16, -1, -1);                                  // LAT=3, full depth
    load(15, m_stim[15], m_exp[15] ^ 8'h80, 8'hFF);
    run(1, 16, -1, -1);                                  // caught in DRAIN
    load_all(1'b1);
    run(0, 16, -1, -1);                                  // saturating counter
    run(0, 0, -1, -1);
    run(1, 0, -1, -1);
    load_all(1'b0);
    run(0, 31, -1, -1);                                  // clamped to DEPTH
    run(0, 16, 3, -1);                                   // start/load while busy
    load(5, m_stim[5], m_exp[5], m_mask[5]);             // idle instance took that write
    load(1, m_stim[1], m_exp[1] ^ 8'h01, 8'hFF);
    run(0, 8, -1, 3);                                    // reset mid-run
    run(0, 8, -1, -1);                                   // rerun after reset
    run(0, 8, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
